// File: rtl/player_movement.sv
// player_movement: turns debounced direction buttons into a clamped, registered
// sprite position. A press steps once immediately, and a held button steps again
// after an initial delay and then at a fixed repeat rate.
module player_movement #(
  parameter int unsigned POS_W         = 10,
  parameter int unsigned X_MIN         = 0,
  parameter int unsigned X_MAX         = 639,
  parameter int unsigned Y_MIN         = 0,
  parameter int unsigned Y_MAX         = 479,
  parameter int unsigned X_INIT        = 320,
  parameter int unsigned Y_INIT        = 240,
  parameter int unsigned STEP          = 1,
  parameter int unsigned DELAY_CYCLES  = 6250000,
  parameter int unsigned REPEAT_CYCLES = 1250000
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_enable,
  input  logic             i_respawn,
  input  logic             i_up,
  input  logic             i_down,
  input  logic             i_left,
  input  logic             i_right,
  output logic [POS_W-1:0] o_player_pos_x,
  output logic [POS_W-1:0] o_player_pos_y,
  output logic             o_step,
  output logic             o_blocked
);

  // Two guard bits keep the signed step sum free of wrap-around.
  localparam int unsigned SW      = POS_W + 2;
  localparam int unsigned MAX_CYC = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNT_W-1:0]     DELAY_LD  = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0]     REPEAT_LD = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic signed [SW-1:0] X_MIN_S   = SW'(X_MIN);
  localparam logic signed [SW-1:0] X_MAX_S   = SW'(X_MAX);
  localparam logic signed [SW-1:0] Y_MIN_S   = SW'(Y_MIN);
  localparam logic signed [SW-1:0] Y_MAX_S   = SW'(Y_MAX);
  localparam logic signed [SW-1:0] STEP_S    = SW'(STEP);
  localparam logic [POS_W-1:0]     X_INIT_P  = POS_W'(X_INIT);
  localparam logic [POS_W-1:0]     Y_INIT_P  = POS_W'(Y_INIT);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   pos_x_q, pos_x_d;
  logic [POS_W-1:0]   pos_y_q, pos_y_d;
  logic               step_q, step_d;
  logic               blocked_q, blocked_d;
  logic [1:0]         sync_q, sync_d;

  logic               dx_pos, dx_neg, dy_pos, dy_neg, active, run;
  logic signed [SW-1:0] x_ext, y_ext, x_sum, y_sum, x_cl, y_cl;
  logic               blk;

  // Direction vector; opposing buttons cancel on their axis.
  always_comb begin
    dx_pos = i_right & ~i_left;
    dx_neg = i_left  & ~i_right;
    dy_pos = i_down  & ~i_up;
    dy_neg = i_up    & ~i_down;
    active = dx_pos | dx_neg | dy_pos | dy_neg;
    run    = sync_q[1];
    sync_d = {sync_q[0], 1'b1};
  end

  // Candidate next position with clamping and blocked detection.
  always_comb begin
    x_ext = signed'({2'b00, pos_x_q});
    y_ext = signed'({2'b00, pos_y_q});
    x_sum = x_ext + (dx_pos ? STEP_S : (dx_neg ? -STEP_S : SW'(0)));
    y_sum = y_ext + (dy_pos ? STEP_S : (dy_neg ? -STEP_S : SW'(0)));
    x_cl  = (x_sum < X_MIN_S) ? X_MIN_S : ((x_sum > X_MAX_S) ? X_MAX_S : x_sum);
    y_cl  = (y_sum < Y_MIN_S) ? Y_MIN_S : ((y_sum > Y_MAX_S) ? Y_MAX_S : y_sum);
    blk   = (x_cl != x_sum) || (y_cl != y_sum);
  end

  // Next-state: respawn over enable/sync gating over the hold/repeat FSM.
  always_comb begin
    logic do_step;
    state_d   = state_q;
    cnt_d     = cnt_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    step_d    = 1'b0;
    blocked_d = 1'b0;
    do_step   = 1'b0;

    if (i_respawn) begin
      pos_x_d = X_INIT_P;
      pos_y_d = Y_INIT_P;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (!i_enable || !run) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (active) begin
            do_step = 1'b1;
            cnt_d   = DELAY_LD;
            state_d = HOLD;
          end
        end
        HOLD, REPEAT: begin
          if (!active) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            do_step = 1'b1;
            cnt_d   = REPEAT_LD;
            state_d = REPEAT;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (do_step) begin
      pos_x_d   = POS_W'(x_cl);
      pos_y_d   = POS_W'(y_cl);
      step_d    = 1'b1;
      blocked_d = blk;
    end
  end

  // State, position and pulse registers with asynchronous reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pos_x_q   <= X_INIT_P;
      pos_y_q   <= Y_INIT_P;
      step_q    <= 1'b0;
      blocked_q <= 1'b0;
      sync_q    <= 2'b00;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      step_q    <= step_d;
      blocked_q <= blocked_d;
      sync_q    <= sync_d;
    end
  end

  assign o_player_pos_x = pos_x_q;
  assign o_player_pos_y = pos_y_q;
  assign o_step         = step_q;
  assign o_blocked      = blocked_q;

endmodule

// File: tb/tb_player_movement.sv
// Directed bench for player_movement on a 16x16 playfield, INIT (8,8),
// STEP 1, DELAY 4, REPEAT 2.
module tb_player_movement;

  logic       clk, rst_n, enable, respawn, up, down, left, right;
  logic [4:0] px, py;
  logic       stp, blk;

  int checks = 0;
  int errors = 0;

  player_movement #(
    .POS_W(5), .X_MIN(0), .X_MAX(15), .Y_MIN(0), .Y_MAX(15),
    .X_INIT(8), .Y_INIT(8), .STEP(1), .DELAY_CYCLES(4), .REPEAT_CYCLES(2)
  ) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_enable(enable), .i_respawn(respawn),
    .i_up(up), .i_down(down), .i_left(left), .i_right(right),
    .o_player_pos_x(px), .o_player_pos_y(py), .o_step(stp), .o_blocked(blk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dir(input logic u, input logic d, input logic l, input logic r);
    up = u; down = d; left = l; right = r;
  endtask

  task automatic do_respawn();
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    check("respawn_x", px, 8);
    check("respawn_y", py, 8);
  endtask

  initial begin
    int sc, bc, ex;
    logic es;
    rst_n = 1'b1; enable = 1'b1; respawn = 1'b0;
    set_dir(0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    check("rst_x", px, 8);
    check("rst_y", py, 8);
    check("rst_step", stp, 0);
    check("rst_blk", blk, 0);
    tick(); tick();
    rst_n = 1'b1;

    // idle after reset: no pulses, position stays at init
    sc = 0; bc = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      sc += int'(stp);
      bc += int'(blk);
    end
    check("idle_steps", sc, 0);
    check("idle_blocked", bc, 0);
    check("idle_x", px, 8);
    check("idle_y", py, 8);

    // right held 10 cycles: steps at t0, t0+4, t0+6, t0+8
    set_dir(0, 0, 0, 1);
    ex = 8;
    for (int i = 0; i < 10; i++) begin
      tick();
      es = (i == 0 || i == 4 || i == 6 || i == 8);
      if (es) ex++;
      check("hold_step", stp, int'(es));
      check("hold_x", px, ex);
    end
    set_dir(0, 0, 0, 0);
    tick();
    check("release_step", stp, 0);
    check("release_x", px, 12);
    check("release_y", py, 8);

    // three up+left pulses
    do_respawn();
    for (int k = 0; k < 3; k++) begin
      set_dir(1, 0, 1, 0);
      tick();
      check("diag_step", stp, 1);
      set_dir(0, 0, 0, 0);
      tick(); tick();
    end
    check("diag_x", px, 5);
    check("diag_y", py, 5);

    // up+down cancels, right still moves
    do_respawn();
    set_dir(1, 1, 0, 1);
    tick();
    check("cancel_x0", px, 9);
    check("cancel_y0", py, 8);
    tick(); tick(); tick();
    check("cancel_wait_step", stp, 0);
    tick();
    check("cancel_x1", px, 10);
    check("cancel_y1", py, 8);
    check("cancel_step1", stp, 1);
    set_dir(0, 0, 0, 0);
    tick();

    // walk to x=1, then hold left into the edge
    do_respawn();
    for (int k = 0; k < 7; k++) begin
      set_dir(0, 0, 1, 0);
      tick();
      set_dir(0, 0, 0, 0);
      tick();
    end
    check("walk_x", px, 1);
    set_dir(0, 0, 1, 0);
    tick();
    check("edge_x0", px, 0);
    check("edge_blk0", blk, 0);
    check("edge_step0", stp, 1);
    tick(); tick(); tick();
    tick();
    check("edge_x1", px, 0);
    check("edge_blk1", blk, 1);
    check("edge_step1", stp, 1);
    set_dir(0, 0, 0, 0);
    tick();
    check("edge_blk_clear", blk, 0);

    // respawn mid-hold, held button then steps as a new press
    do_respawn();
    set_dir(0, 0, 0, 1);
    tick();
    check("rsp_x0", px, 9);
    tick(); tick(); tick(); tick();
    check("rsp_x4", px, 10);
    respawn = 1'b1;
    tick();
    respawn = 1'b0;
    check("rsp_x5", px, 8);
    check("rsp_y5", py, 8);
    check("rsp_step5", stp, 0);
    tick();
    check("rsp_x6", px, 9);
    check("rsp_step6", stp, 1);
    set_dir(0, 0, 0, 0);
    tick();

    // enable low freezes the position while buttons toggle
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_dir(i % 2 == 0, i % 3 == 1, i % 3 == 0, i % 2 == 1);
      tick();
      check("dis_x", px, 9);
      check("dis_y", py, 8);
      check("dis_step", stp, 0);
    end
    set_dir(0, 0, 0, 0);
    enable = 1'b1;
    tick();

    // asynchronous reset in the middle of REPEAT
    set_dir(0, 0, 0, 1);
    tick();
    check("rep_x0", px, 10);
    tick(); tick(); tick(); tick();
    check("rep_x4", px, 11);
    tick(); tick();
    check("rep_x6", px, 12);
    #3 rst_n = 1'b0;
    #1;
    check("arst_x", px, 8);
    check("arst_y", py, 8);
    check("arst_step", stp, 0);

    // release with right held: first step on the third edge
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    check("sync_e1_x", px, 8);
    tick();
    check("sync_e2_x", px, 8);
    check("sync_e2_step", stp, 0);
    tick();
    check("sync_e3_x", px, 9);
    check("sync_e3_step", stp, 1);
    set_dir(0, 0, 0, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/player_movement.md
# player_movement

Parametrised player-position controller for the VGA game. It converts the four direction buttons into a registered (x, y) sprite position with per-axis step size and clamping to a playfield rectangle. A press moves the player once immediately; holding moves again after an initial delay and then at a fixed repeat rate. It sits between the debounced button inputs and the sprite/renderer logic, which consumes `o_player_pos_x` and `o_player_pos_y`.

## Interface
- `POS_W`, 10: width of each coordinate output.
- `X_MIN`, 0: leftmost legal x.
- `X_MAX`, 639: rightmost legal x.
- `Y_MIN`, 0: topmost legal y.
- `Y_MAX`, 479: bottommost legal y.
- `X_INIT`, 320: x loaded on reset and on respawn.
- `Y_INIT`, 240: y loaded on reset and on respawn.
- `STEP`, 1: pixels moved per step on each active axis; must be ≥1.
- `DELAY_CYCLES`, 6250000: cycles from the first step to the second while held; must be ≥1.
- `REPEAT_CYCLES`, 1250000: cycles between subsequent held steps; must be ≥1.

Ports:
- `i_Clk` in 1: system clock.
- `i_Rst_n` in 1: asynchronous, active-low reset.
- `i_enable` in 1: movement enable. Low freezes the position and returns the FSM to IDLE.
- `i_respawn` in 1: synchronous load of (`X_INIT`, `Y_INIT`).
- `i_up`, `i_down`, `i_left`, `i_right` in 1 each: synchronous, debounced level inputs.
- `o_player_pos_x` out POS_W: current x.
- `o_player_pos_y` out POS_W: current y.
- `o_step` out 1: one-cycle pulse on every cycle a step is applied.
- `o_blocked` out 1: one-cycle pulse when a step was clamped on either axis.

## Operation
- Direction vector, evaluated every cycle:
  - dx = right − left; both pressed gives 0.
  - dy = down − up; both pressed gives 0.
  - `active` = (dx ≠ 0) or (dy ≠ 0).
- Diagonal movement is allowed. Both axes move in the same step.
- FSM states:
  - IDLE: on `active`, apply a step, load counter = DELAY_CYCLES−1, go to HOLD.
  - HOLD: if not `active`, go to IDLE. Otherwise, if counter = 0, apply a step, load counter = REPEAT_CYCLES−1, go to REPEAT; else decrement the counter.
  - REPEAT: if not `active`, go to IDLE. Otherwise, if counter = 0, apply a step and reload REPEAT_CYCLES−1; else decrement the counter.
- Changing to a different non-zero vector while held does not restart timing. The next step uses the vector present on that cycle.
- Step arithmetic is done at POS_W+2 bits signed, with no wrap-around:
  - x' = x + dx·STEP, then clamp to [X_MIN, X_MAX].
  - y' = y + dy·STEP, then clamp to [Y_MIN, Y_MAX].
  - `o_blocked` = 1 if either axis result differed from its unclamped value. This includes the case of already being at the edge.
- Priority per cycle, highest first:
  1. `i_respawn`: position ← INIT, FSM ← IDLE, counter ← 0. No step and no pulses that cycle.
  2. `!i_enable`: FSM ← IDLE, counter ← 0. Position held, no pulses.
  3. Normal FSM operation.
- A button held through a respawn or an enable-low period is seen as a new press on the first normal cycle: it steps immediately.
- Counter width is clog2(max(DELAY_CYCLES, REPEAT_CYCLES)).

## Timing
- Reset values, all applied asynchronously while `i_Rst_n` = 0:
  - `o_player_pos_x` = X_INIT, `o_player_pos_y` = Y_INIT.
  - `o_step` = 0, `o_blocked` = 0.
  - FSM = IDLE, counter = 0.
- Reset deassertion is synchronised internally (2-flop release). The first press is honoured no earlier than the third rising edge after release.
- Latency: a button asserted before edge t0 produces the new position, `o_step`, and `o_blocked` registered at edge t0.
- Held button: steps occur at t0, t0+DELAY_CYCLES, then t0+DELAY_CYCLES+k·REPEAT_CYCLES for k ≥ 1.
- Release before edge t moves the FSM to IDLE at t; no step occurs at t.
- Reset mid-hold: the position returns to INIT immediately, with no partial step.

## Test plan
Parameters for all scenarios: POS_W=5, bounds 0..15, INIT (8,8), STEP=1, DELAY=4, REPEAT=2.

- Reset with all inputs low → pos (8,8); `o_step` = 0 and `o_blocked` = 0 for 20 cycles.
- `i_right` held for 10 cycles from edge t0 → x = 9 @t0, 10 @t0+4, 11 @t0+6, 12 @t0+8; `o_step` high exactly on those edges.
- Up+left pulsed for 1 cycle three times, 3 cycles apart → pos (5,5); up+down+right held → x increments, y stays 8.
- Left held from x = 1 → x = 0 with `o_blocked` = 0; the next step keeps x = 0 with `o_blocked` = 1 and `o_step` = 1.
- Right held, `i_respawn` pulsed at t0+5 → pos (8,8) at t0+5 with no step; the next step is at t0+6 (treated as a new press) → x = 9.
- `i_enable` low with buttons toggling → pos constant; `i_Rst_n` low mid-REPEAT → pos (8,8) asynchronously, before the next edge.
